inv_add_round_key_stage: RTL



---
 rtl/inv_add_round_key_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/inv_add_round_key_stage.sv
// Inverse-cipher AddRoundKey stage: round-key file, descending round
// counter and a one-entry registered output with valid/ready handshake.
module inv_add_round_key_stage #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         key_we,
   input  logic [3:0]   key_waddr,
   input  logic [127:0] key_wdata,
   input  logic         start,
   input  logic [127:0] data_in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [127:0] data_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [3:0]   round,
   output logic         mix_en,
   output logic         last,
   output logic         err
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_e;

   state_e         state_q, state_d;
   logic [3:0]     rcnt_q, rcnt_d;
   logic [127:0]   key_q [NUM_ROUNDS+1];
   logic [127:0]   data_q, data_d;
   logic [3:0]     round_q, round_d;
   logic           mix_q, mix_d;
   logic           last_q, last_d;
   logic           valid_q, valid_d;
   logic           err_q, err_d;
   logic           accept;
   logic [3:0]     idx;

   // IDLE only admits the first beat of a block
   assign in_ready = n_rst && (!valid_q || out_ready)
                     && (state_q == ACTIVE || start);
   assign accept   = in_valid && in_ready;
   assign idx      = start ? LAST_IDX : rcnt_q;

   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      data_d  = data_q;
      round_d = round_q;
      mix_d   = mix_q;
      last_d  = last_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      if (accept) begin
         data_d  = data_in ^ key_q[idx];
         round_d = idx;
         mix_d   = (idx != 4'd0) && (idx != LAST_IDX);
         last_d  = (idx == 4'd0);
         valid_d = 1'b1;
         if (start) begin
            state_d = ACTIVE;
            rcnt_d  = LAST_IDX - 4'd1;
            err_d   = (state_q == ACTIVE);
         end else if (rcnt_q == 4'd0) begin
            state_d = IDLE;
         end else begin
            rcnt_d = rcnt_q - 4'd1;
         end
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= IDLE;
         rcnt_q  <= '0;
         data_q  <= '0;
         round_q <= '0;
         mix_q   <= 1'b0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         data_q  <= data_d;
         round_q <= round_d;
         mix_q   <= mix_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // same-cycle write/accept collision naturally reads the old key
   always_ff @(posedge clk) begin
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
         if (!n_rst) begin
            key_q[i] <= '0;
         end else if (key_we && key_waddr == 4'(i)) begin
            key_q[i] <= key_wdata;
         end
      end
   end

   assign data_out  = data_q;
   assign round     = round_q;
   assign mix_en    = mix_q;
   assign last      = last_q;
   assign out_valid = valid_q;
   assign err       = err_q;

endmodule
